cheri_dec_stage: RTL and testbench
==================================

# cheri_dec_stage

Registered CHERI decode pipeline stage that sits between instruction fetch and the ibex decoder/cheri_EX. It classifies raw 32-bit instructions itself (no externally pre-decoded opcode enables), produces the one-hot CHERI operator, a unified 32-bit immediate and register-file controls, and buffers the results in a DEPTH-entry decoded-instruction queue with valid/ready handshakes on both sides. Operators that need two cycles are sequenced at the queue head so downstream logic never needs to count cycles itself.

## Interface
- DEPTH, 2: decoded-queue entries; legal range 1..8.
- CheriPPLBC, 1'b1: pipelined load-cap-with-tag; when 0, CLOAD_CAP under tsafe is multicycle.
- CheriSBND2, 1'b0: two-cycle bounds ops (CSET_BOUNDS, CSET_BOUNDS_IMM, CSET_BOUNDS_EX, CRRL, CRAM).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cheri_en_i  in  1  CHERI decoding enabled; 0 makes every instruction non-CHERI.
- cheri_tsafe_en_i  in  1  temporal-safety mode.
- flush_i  in  1  discard all queued and in-progress entries.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  stage can accept.
- in_instr_i  in  32  raw instruction.
- in_pc_i  in  32  instruction PC.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head.
- out_pc_o  out  32  head PC.
- out_is_cheri_o  out  1  instruction in CHERI space.
- out_legal_o  out  1  OR-reduction of out_operator_o.
- out_operator_o  out  OPDW  one-hot operator (cheri_pkg indices).
- out_imm_o  out  32  unified immediate.
- out_cs2_o  out  5  SCR index for CCSR_RW, else 0.
- out_rf_ren_a_o, out_rf_ren_b_o, out_rf_we_o  out  1 each  register-file controls.
- out_multicycle_o  out  1  head op was two-cycle.
- occupancy_o  out  $clog2(DEPTH+1)  queued entries.
- perf_decoded_o, perf_illegal_o  out  32 each  performance counters.

## Operation
- Classification (all gated by cheri_en_i): 0x5b opcode space; AUIPCC 0x17; AUICGP 0x7b; JALR 0x67; JAL 0x6f; CLOAD_CAP 0x03 with func3=3; CSTORE_CAP 0x23 with func3=3.
- 0x5b sub-decode: func3=0 R-format via func7 (0x01 CCSR_RW, 0x08 CSET_BOUNDS, 0x09 CSET_BOUNDS_EX, 0x0b CSEAL, 0x0c CUNSEAL, 0x0d CAND_PERM, 0x10 CSET_ADDR, 0x11 CINC_ADDR, 0x14 CSUB_CAP, 0x20 CIS_SUBSET, 0x21 CIS_EQUAL); func7=0x7f via imm5 (0x00 PERM, 0x01 TYPE, 0x02 BASE, 0x18 TOP, 0x03 LEN, 0x04 TAG, 0x08 CRRL, 0x09 CRAM, 0x0f ADDR, 0x0a CMOVE, 0x0b CCLEAR_TAG); func3=1 CINC_ADDR_IMM; func3=2 CSET_BOUNDS_IMM. Other encodings: is_cheri=1, legal=0.
- Immediate: JALR/CINC_ADDR_IMM/CLOAD_CAP sign-extend instr[31:20]; CSET_BOUNDS_IMM zero-extends instr[31:20]; CSTORE_CAP sign-extends {instr[31:25],instr[11:7]}; AUIPCC/AUICGP {instr[31:12],12'h0}; JAL sign-extended J-immediate with bit0=0; else 0.
- rf_ren_a=1 for 0x5b; rf_ren_b=(func3==0)&&(func7!=0x7f) for 0x5b; rf_we=1 for every CHERI class except CSTORE_CAP. Non-CHERI: all controls 0.
- Multicycle = (CLOAD_CAP & tsafe & ~CheriPPLBC) | (CheriSBND2 & bounds ops); computed at enqueue and stored.
- Queue: circular buffer, write/read pointers wrap at DEPTH. in_ready_o = not full, or full with head popping this cycle (pop-through allowed). Enqueue on in_valid_i&in_ready_o.
- Head sequencing FSM: IDLE → (head multicycle) HOLD1 → PRESENT. HOLD1 lasts exactly one cycle with out_valid_o=0; PRESENT asserts out_valid_o until out_ready_i; single-cycle heads go straight to PRESENT.

## Timing
- Enqueue-to-out_valid latency: 1 cycle (single-cycle op into empty queue), 2 cycles (multicycle op).
- Output payload comes from registers; no combinational in→out path. in_ready_o depends combinationally on out_ready_i only.
- Simultaneous push and pop when full: both occur, occupancy unchanged.
- Empty: out_valid_o=0, payload outputs hold last value (don't-care).
- flush_i has priority over push/pop in the same cycle: pointers, occupancy, FSM cleared next cycle; in_ready_o=1 during flush cycle but the offered instruction is discarded.
- Reset (any cycle, including mid-HOLD1): all pointers, occupancy_o, FSM=IDLE, out_valid_o=0, all payload outputs 0, perf counters 0.

## Configuration
- CHERI_DEC_PERF_EN defined: perf_decoded_o increments on each enqueued instruction with is_cheri=1; perf_illegal_o on each enqueued is_cheri=1, legal=0. Both saturate at 32'hFFFF_FFFF, cleared by reset only (not flush).
- Undefined: counter registers absent, both ports tied to 0.

## Test plan
- Push 0xFFF090DB (CINC_ADDR_IMM, imm 0xFFF) into empty queue, out_ready_i=1 -> next cycle out_valid_o=1, CINC_ADDR_IMM bit set, out_imm_o=0xFFFF_FFFF, rf_we=1, rf_ren_b=0.
- CheriSBND2=1, push 0x102080DB (CSET_BOUNDS) -> out_valid_o low for 1 cycle, high the following cycle, out_multicycle_o=1, rf_ren_b=1.
- DEPTH=2, out_ready_i=0, push 3 instructions -> third stalls with in_ready_o=0, occupancy_o=2; raise out_ready_i -> third accepted same cycle, order preserved.
- cheri_en_i=0, push 0x102080DB -> out_is_cheri_o=0, out_legal_o=0, operator all zero.
- Fill queue, assert flush_i with in_valid_i=1 -> next cycle occupancy_o=0, out_valid_o=0, flushed-cycle instruction not delivered.
- With CHERI_DEC_PERF_EN, push 0x5b instruction func3=0, func7=0x7e -> perf_decoded_o=1, perf_illegal_o=1; then reset -> both 0.

Source files
------------

// File: rtl/cheri_dec_stage.sv
// cheri_dec_stage
//   Registered CHERI decode stage between instruction fetch and the
//   decoder/EX. Raw 32-bit instructions are classified here, turned into a
//   one-hot operator, a unified immediate and register-file controls, and then
//   buffered in a DEPTH-entry decoded-instruction queue. Two-cycle operators
//   are sequenced at the queue head (one dead cycle before they are
//   presented), so downstream logic never has to count cycles itself.
//
//   Optional feature macro: CHERI_DEC_PERF_EN (performance counters). When the
//   macro is undefined the counter registers are absent and the perf ports
//   read 0.
//
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     cheri_en_i                   CHERI decoding enable (0: nothing is CHERI)
//     cheri_tsafe_en_i             temporal-safety mode (affects CLOAD_CAP)
//     flush_i                      drop all queued and in-progress entries
//     in_valid_i/in_ready_o        instruction handshake
//     in_instr_i, in_pc_i          raw instruction and its PC
//     out_valid_o/out_ready_i      head-entry handshake
//     out_pc_o .. out_multicycle_o decoded payload of the head entry
//     occupancy_o                  number of queued entries
//     perf_decoded_o/illegal_o     saturating event counters
//
//   Operator bit map (out_operator_o):
//     0 CCSR_RW  1 CSET_BOUNDS  2 CSET_BOUNDS_EX  3 CSEAL  4 CUNSEAL
//     5 CAND_PERM  6 CSET_ADDR  7 CINC_ADDR  8 CSUB_CAP  9 CIS_SUBSET
//     10 CIS_EQUAL  11 CGET_PERM  12 CGET_TYPE  13 CGET_BASE  14 CGET_TOP
//     15 CGET_LEN  16 CGET_TAG  17 CRRL  18 CRAM  19 CGET_ADDR  20 CMOVE
//     21 CCLEAR_TAG  22 CINC_ADDR_IMM  23 CSET_BOUNDS_IMM  24 CJALR  25 CJAL
//     26 AUIPCC  27 AUICGP  28 CLOAD_CAP  29 CSTORE_CAP

module cheri_dec_stage #(
  parameter int   DEPTH      = 2,
  parameter logic CheriPPLBC = 1'b1,
  parameter logic CheriSBND2 = 1'b0,
  localparam int  OPDW       = 30
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cheri_en_i,
  input  logic                         cheri_tsafe_en_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  in_instr_i,
  input  logic [31:0]                  in_pc_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_pc_o,
  output logic                         out_is_cheri_o,
  output logic                         out_legal_o,
  output logic [OPDW-1:0]              out_operator_o,
  output logic [31:0]                  out_imm_o,
  output logic [4:0]                   out_cs2_o,
  output logic                         out_rf_ren_a_o,
  output logic                         out_rf_ren_b_o,
  output logic                         out_rf_we_o,
  output logic                         out_multicycle_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic [31:0]                  perf_decoded_o,
  output logic [31:0]                  perf_illegal_o
);
  // Decode + DEPTH-entry queue with head sequencing for two-cycle operators.
  // Latency: 1 cycle enqueue-to-valid (2 for multicycle heads); payload registered.
  // Backpressure: in_ready_o low only when full and the head is not popping.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam int OP_CCSR_RW         = 0;
  localparam int OP_CSET_BOUNDS     = 1;
  localparam int OP_CSET_BOUNDS_EX  = 2;
  localparam int OP_CSEAL           = 3;
  localparam int OP_CUNSEAL         = 4;
  localparam int OP_CAND_PERM       = 5;
  localparam int OP_CSET_ADDR       = 6;
  localparam int OP_CINC_ADDR       = 7;
  localparam int OP_CSUB_CAP        = 8;
  localparam int OP_CIS_SUBSET      = 9;
  localparam int OP_CIS_EQUAL       = 10;
  localparam int OP_CGET_PERM       = 11;
  localparam int OP_CGET_TYPE       = 12;
  localparam int OP_CGET_BASE       = 13;
  localparam int OP_CGET_TOP        = 14;
  localparam int OP_CGET_LEN        = 15;
  localparam int OP_CGET_TAG        = 16;
  localparam int OP_CRRL            = 17;
  localparam int OP_CRAM            = 18;
  localparam int OP_CGET_ADDR       = 19;
  localparam int OP_CMOVE           = 20;
  localparam int OP_CCLEAR_TAG      = 21;
  localparam int OP_CINC_ADDR_IMM   = 22;
  localparam int OP_CSET_BOUNDS_IMM = 23;
  localparam int OP_CJALR           = 24;
  localparam int OP_CJAL            = 25;
  localparam int OP_AUIPCC          = 26;
  localparam int OP_AUICGP          = 27;
  localparam int OP_CLOAD_CAP       = 28;
  localparam int OP_CSTORE_CAP      = 29;

  typedef struct packed {
    logic [31:0]     pc;
    logic            is_cheri;
    logic [OPDW-1:0] op;
    logic [31:0]     imm;
    logic [4:0]      cs2;
    logic            ren_a;
    logic            ren_b;
    logic            we;
    logic            mc;
  } dec_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD1   = 2'd1,
    S_PRESENT = 2'd2
  } head_state_t;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [4:0] imm5;

  assign opcode = in_instr_i[6:0];
  assign func3  = in_instr_i[14:12];
  assign func7  = in_instr_i[31:25];
  assign imm5   = in_instr_i[24:20];

  dec_t d_entry;

  always_comb begin
    d_entry    = '0;
    d_entry.pc = in_pc_i;
    if (cheri_en_i) begin
      case (opcode)
        7'h5b: begin
          d_entry.is_cheri = 1'b1;
          d_entry.ren_a    = 1'b1;
          d_entry.ren_b    = (func3 == 3'd0) && (func7 != 7'h7f);
          d_entry.we       = 1'b1;
          case (func3)
            3'd0: begin
              if (func7 == 7'h7f) begin
                // Single-source ops: the rs2 field selects the operator.
                case (imm5)
                  5'h00:   d_entry.op[OP_CGET_PERM]  = 1'b1;
                  5'h01:   d_entry.op[OP_CGET_TYPE]  = 1'b1;
                  5'h02:   d_entry.op[OP_CGET_BASE]  = 1'b1;
                  5'h18:   d_entry.op[OP_CGET_TOP]   = 1'b1;
                  5'h03:   d_entry.op[OP_CGET_LEN]   = 1'b1;
                  5'h04:   d_entry.op[OP_CGET_TAG]   = 1'b1;
                  5'h08:   d_entry.op[OP_CRRL]       = 1'b1;
                  5'h09:   d_entry.op[OP_CRAM]       = 1'b1;
                  5'h0f:   d_entry.op[OP_CGET_ADDR]  = 1'b1;
                  5'h0a:   d_entry.op[OP_CMOVE]      = 1'b1;
                  5'h0b:   d_entry.op[OP_CCLEAR_TAG] = 1'b1;
                  default: d_entry.op = '0;
                endcase
              end else begin
                case (func7)
                  7'h01: begin
                    d_entry.op[OP_CCSR_RW] = 1'b1;
                    d_entry.cs2            = imm5;
                  end
                  7'h08:   d_entry.op[OP_CSET_BOUNDS]    = 1'b1;
                  7'h09:   d_entry.op[OP_CSET_BOUNDS_EX] = 1'b1;
                  7'h0b:   d_entry.op[OP_CSEAL]          = 1'b1;
                  7'h0c:   d_entry.op[OP_CUNSEAL]        = 1'b1;
                  7'h0d:   d_entry.op[OP_CAND_PERM]      = 1'b1;
                  7'h10:   d_entry.op[OP_CSET_ADDR]      = 1'b1;
                  7'h11:   d_entry.op[OP_CINC_ADDR]      = 1'b1;
                  7'h14:   d_entry.op[OP_CSUB_CAP]       = 1'b1;
                  7'h20:   d_entry.op[OP_CIS_SUBSET]     = 1'b1;
                  7'h21:   d_entry.op[OP_CIS_EQUAL]      = 1'b1;
                  default: d_entry.op = '0;
                endcase
              end
            end
            3'd1: begin
              d_entry.op[OP_CINC_ADDR_IMM] = 1'b1;
              d_entry.imm = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            end
            3'd2: begin
              d_entry.op[OP_CSET_BOUNDS_IMM] = 1'b1;
              d_entry.imm = {20'h0, in_instr_i[31:20]};
            end
            default: d_entry.op = '0;
          endcase
        end
        7'h17: begin
          d_entry.is_cheri       = 1'b1;
          d_entry.op[OP_AUIPCC]  = 1'b1;
          d_entry.imm            = {in_instr_i[31:12], 12'h0};
          d_entry.we             = 1'b1;
        end
        7'h7b: begin
          d_entry.is_cheri       = 1'b1;
          d_entry.op[OP_AUICGP]  = 1'b1;
          d_entry.imm            = {in_instr_i[31:12], 12'h0};
          d_entry.we             = 1'b1;
        end
        7'h67: begin
          d_entry.is_cheri       = 1'b1;
          d_entry.op[OP_CJALR]   = 1'b1;
          d_entry.imm            = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
          d_entry.we             = 1'b1;
        end
        7'h6f: begin
          d_entry.is_cheri       = 1'b1;
          d_entry.op[OP_CJAL]    = 1'b1;
          d_entry.imm            = {{12{in_instr_i[31]}}, in_instr_i[19:12],
                                    in_instr_i[20], in_instr_i[30:21], 1'b0};
          d_entry.we             = 1'b1;
        end
        7'h03: begin
          if (func3 == 3'd3) begin
            d_entry.is_cheri         = 1'b1;
            d_entry.op[OP_CLOAD_CAP] = 1'b1;
            d_entry.imm              = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            d_entry.we               = 1'b1;
          end
        end
        7'h23: begin
          if (func3 == 3'd3) begin
            d_entry.is_cheri          = 1'b1;
            d_entry.op[OP_CSTORE_CAP] = 1'b1;
            d_entry.imm               = {{20{in_instr_i[31]}}, in_instr_i[31:25],
                                         in_instr_i[11:7]};
          end
        end
        default: d_entry.is_cheri = 1'b0;
      endcase
    end

    // The two-cycle decision is frozen at enqueue so later changes of the
    // tsafe mode cannot alter an entry already in flight.
    d_entry.mc = (d_entry.op[OP_CLOAD_CAP] & cheri_tsafe_en_i & ~CheriPPLBC) |
                 (CheriSBND2 & (d_entry.op[OP_CSET_BOUNDS]     |
                                d_entry.op[OP_CSET_BOUNDS_IMM] |
                                d_entry.op[OP_CSET_BOUNDS_EX]  |
                                d_entry.op[OP_CRRL]            |
                                d_entry.op[OP_CRAM]));
  end

  // ---------------------------------------------------------------------------
  // Decoded-instruction queue
  // ---------------------------------------------------------------------------
  dec_t            q_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CW-1:0]   count_q, count_d;
  logic            full;
  logic            push, pop;
  logic            head_mc_nxt;
  head_state_t     state_q, state_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  // Pop-through: a full queue can still accept while its head leaves.
  assign in_ready_o = flush_i | ~full | pop;
  assign push       = in_valid_i & in_ready_o & ~flush_i;
  assign rd_ptr_nxt = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Multicycle flag of whichever entry will sit at the head after this edge:
  // an entry already queued behind the current head, or the one being pushed.
  always_comb begin
    head_mc_nxt = d_entry.mc;
    if (pop ? (count_q > CW'(1)) : (count_q != '0)) begin
      head_mc_nxt = q_mem[rd_ptr_nxt].mc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_nxt;
        if (push) begin
          q_mem[wr_ptr_q] <= d_entry;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IDLE is held exactly while the queue is empty.
  always_comb begin
    state_d = state_q;
    if (flush_i || (count_d == '0)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_HOLD1:   state_d = S_PRESENT;
        S_PRESENT: state_d = pop ? (head_mc_nxt ? S_HOLD1 : S_PRESENT) : S_PRESENT;
        default:   state_d = head_mc_nxt ? S_HOLD1 : S_PRESENT;
      endcase
    end
  end

  always_comb begin
    out_valid_o = (state_q == S_PRESENT);
    pop         = (state_q == S_PRESENT) & out_ready_i;
  end

  // ---------------------------------------------------------------------------
  // Head payload (straight from queue registers)
  // ---------------------------------------------------------------------------
  dec_t head;
  assign head             = q_mem[rd_ptr_q];
  assign out_pc_o         = head.pc;
  assign out_is_cheri_o   = head.is_cheri;
  assign out_legal_o      = |head.op;
  assign out_operator_o   = head.op;
  assign out_imm_o        = head.imm;
  assign out_cs2_o        = head.cs2;
  assign out_rf_ren_a_o   = head.ren_a;
  assign out_rf_ren_b_o   = head.ren_b;
  assign out_rf_we_o      = head.we;
  assign out_multicycle_o = head.mc;
  assign occupancy_o      = count_q;

  // ---------------------------------------------------------------------------
  // Performance counters (survive flush, cleared by reset only)
  // ---------------------------------------------------------------------------
`ifdef CHERI_DEC_PERF_EN
  logic [31:0] perf_dec_q, perf_ill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_dec_q <= '0;
      perf_ill_q <= '0;
    end else if (push && d_entry.is_cheri) begin
      if (perf_dec_q != 32'hFFFF_FFFF) begin
        perf_dec_q <= perf_dec_q + 32'd1;
      end
      if (!(|d_entry.op) && (perf_ill_q != 32'hFFFF_FFFF)) begin
        perf_ill_q <= perf_ill_q + 32'd1;
      end
    end
  end

  assign perf_decoded_o = perf_dec_q;
  assign perf_illegal_o = perf_ill_q;
`else
  assign perf_decoded_o = 32'h0;
  assign perf_illegal_o = 32'h0;
`endif

endmodule

// File: tb/tb_cheri_dec_stage.sv
// tb_cheri_dec_stage
//   Scoreboarded bench for cheri_dec_stage (DEPTH=2, two-cycle bounds ops and
//   non-pipelined CLOAD_CAP so head sequencing is exercised). Expected decode
//   results come from a hand-written vector table.

module tb_cheri_dec_stage;

  localparam int DEPTH = 2;
  localparam int OPDW  = 30;
  localparam int CW    = $clog2(DEPTH + 1);

  // Operator bit positions of out_operator_o.
  localparam int CCSR_RW = 0, CSET_BOUNDS = 1, CSEAL = 3, CIS_EQUAL = 10;
  localparam int CGET_LEN = 15, CRAM = 18, CINC_ADDR_IMM = 22, CSET_BOUNDS_IMM = 23;
  localparam int CJALR = 24, CJAL = 25, AUIPCC = 26, AUICGP = 27;
  localparam int CLOAD_CAP = 28, CSTORE_CAP = 29;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            cheri_en_i, cheri_tsafe_en_i, flush_i;
  logic            in_valid_i, in_ready_o;
  logic [31:0]     in_instr_i, in_pc_i;
  logic            out_valid_o, out_ready_i;
  logic [31:0]     out_pc_o;
  logic            out_is_cheri_o, out_legal_o;
  logic [OPDW-1:0] out_operator_o;
  logic [31:0]     out_imm_o;
  logic [4:0]      out_cs2_o;
  logic            out_rf_ren_a_o, out_rf_ren_b_o, out_rf_we_o, out_multicycle_o;
  logic [CW-1:0]   occupancy_o;
  logic [31:0]     perf_decoded_o, perf_illegal_o;

  cheri_dec_stage #(.DEPTH(DEPTH), .CheriPPLBC(1'b0), .CheriSBND2(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cheri_en_i(cheri_en_i),
    .cheri_tsafe_en_i(cheri_tsafe_en_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_is_cheri_o(out_is_cheri_o), .out_legal_o(out_legal_o),
    .out_operator_o(out_operator_o), .out_imm_o(out_imm_o), .out_cs2_o(out_cs2_o),
    .out_rf_ren_a_o(out_rf_ren_a_o), .out_rf_ren_b_o(out_rf_ren_b_o),
    .out_rf_we_o(out_rf_we_o), .out_multicycle_o(out_multicycle_o),
    .occupancy_o(occupancy_o), .perf_decoded_o(perf_decoded_o),
    .perf_illegal_o(perf_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------- checking
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [31:0] instr;
    logic        en, ts;
    logic        is_cheri;
    int          op;        // -1: no operator (illegal or non-CHERI)
    logic [31:0] imm;
    logic [4:0]  cs2;
    logic        ra, rb, we, mc;
  } vec_t;

  typedef struct {
    logic [31:0]     pc;
    logic            is_cheri;
    logic [OPDW-1:0] op;
    logic [31:0]     imm;
    logic [4:0]      cs2;
    logic [2:0]      ctl;
    logic            mc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add_vec(input logic [31:0] instr, input logic en, input logic ts,
                         input logic is_cheri, input int op, input logic [31:0] imm,
                         input logic [4:0] cs2, input logic ra, input logic rb,
                         input logic we, input logic mc);
    vec_t v;
    v.instr = instr; v.en = en; v.ts = ts; v.is_cheri = is_cheri; v.op = op;
    v.imm = imm; v.cs2 = cs2; v.ra = ra; v.rb = rb; v.we = we; v.mc = mc;
    vecs.push_back(v);
  endtask

  function automatic exp_t mk_exp(input int idx, input logic [31:0] pc);
    exp_t e;
    e.pc       = pc;
    e.is_cheri = vecs[idx].is_cheri;
    e.op       = '0;
    if (vecs[idx].op >= 0) e.op[vecs[idx].op] = 1'b1;
    e.imm      = vecs[idx].imm;
    e.cs2      = vecs[idx].cs2;
    e.ctl      = {vecs[idx].ra, vecs[idx].rb, vecs[idx].we};
    e.mc       = vecs[idx].mc;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  int          cur_idx = 0;
  logic [31:0] exp_dec = 0, exp_ill = 0;
  exp_t        mon_e;

  function automatic logic [31:0] perf_exp(input logic [31:0] x);
`ifdef CHERI_DEC_PERF_EN
    return x;
`else
    return 32'h0 & x;
`endif
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (out_valid_o && out_ready_i) begin
        chk("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("pc",        out_pc_o,         mon_e.pc);
          chk("is_cheri",  out_is_cheri_o,   mon_e.is_cheri);
          chk("legal",     out_legal_o,      |mon_e.op);
          chk("operator",  out_operator_o,   mon_e.op);
          chk("imm",       out_imm_o,        mon_e.imm);
          chk("cs2",       out_cs2_o,        mon_e.cs2);
          chk("rf_ctl",    {out_rf_ren_a_o, out_rf_ren_b_o, out_rf_we_o}, mon_e.ctl);
          chk("multicyc",  out_multicycle_o, mon_e.mc);
        end
      end
      if (in_valid_i && in_ready_o && !flush_i) begin
        sb.push_back(mk_exp(cur_idx, in_pc_i));
        if (vecs[cur_idx].is_cheri) begin
          exp_dec++;
          if (vecs[cur_idx].op < 0) exp_ill++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  logic [31:0] pc_ctr = 32'h8000_0000;

  task automatic start_push(input int idx);
    cur_idx          = idx;
    in_instr_i       = vecs[idx].instr;
    cheri_en_i       = vecs[idx].en;
    cheri_tsafe_en_i = vecs[idx].ts;
    in_pc_i          = pc_ctr;
    pc_ctr           = pc_ctr + 32'd4;
    in_valid_i       = 1'b1;
  endtask

  // Returns at posedge+1 after the accepting edge. A stalled push opens the
  // consumer so the wait always ends.
  task automatic wait_accept(output int cycles);
    bit acc;
    acc    = 1'b0;
    cycles = 0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk_i);
      acc = in_ready_o && !flush_i;
      cycles++;
      @(posedge clk_i); #1;
      if (!acc) out_ready_i = 1'b1;
    end
    in_valid_i = 1'b0;
    chk("accept", acc, 1'b1);
  endtask

  task automatic push_one(input int idx);
    int c;
    start_push(idx);
    wait_accept(c);
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk_i);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int cyc;
    // instr, en, ts, is_cheri, op, imm, cs2, ra, rb, we, mc
    add_vec(32'hFFF090DB, 1, 0, 1, CINC_ADDR_IMM,   32'hFFFF_FFFF, 0, 1, 0, 1, 0); // 0
    add_vec(32'h102080DB, 1, 0, 1, CSET_BOUNDS,     32'h0,         0, 1, 1, 1, 1); // 1
    add_vec({7'h01, 5'h1c, 5'd1, 3'd0, 5'd2, 7'h5b}, 1, 0, 1, CCSR_RW, 32'h0, 5'h1c, 1, 1, 1, 0); // 2
    add_vec({7'h7f, 5'h03, 5'd1, 3'd0, 5'd2, 7'h5b}, 1, 0, 1, CGET_LEN, 32'h0, 0, 1, 0, 1, 0); // 3
    add_vec({7'h7f, 5'h09, 5'd1, 3'd0, 5'd2, 7'h5b}, 1, 0, 1, CRAM, 32'h0, 0, 1, 0, 1, 1);     // 4
    add_vec({12'h800, 5'd1, 3'd2, 5'd2, 7'h5b}, 1, 0, 1, CSET_BOUNDS_IMM, 32'h800, 0, 1, 0, 1, 1); // 5
    add_vec({20'hABCDE, 5'd3, 7'h17}, 1, 0, 1, AUIPCC, 32'hABCD_E000, 0, 0, 0, 1, 0);         // 6
    add_vec({1'b1, 10'h155, 1'b1, 8'hA5, 5'd1, 7'h6f}, 1, 0, 1, CJAL, 32'hFFFA_5AAA, 0, 0, 0, 1, 0); // 7
    add_vec({7'h40, 5'd5, 5'd1, 3'd3, 5'h1f, 7'h23}, 1, 0, 1, CSTORE_CAP, 32'hFFFF_F81F, 0, 0, 0, 0, 0); // 8
    add_vec({12'h010, 5'd1, 3'd3, 5'd2, 7'h03}, 1, 0, 1, CLOAD_CAP, 32'h10, 0, 0, 0, 1, 0);   // 9
    add_vec({12'h010, 5'd1, 3'd3, 5'd2, 7'h03}, 1, 1, 1, CLOAD_CAP, 32'h10, 0, 0, 0, 1, 1);   // 10
    add_vec({7'h7e, 5'd0, 5'd1, 3'd0, 5'd2, 7'h5b}, 1, 0, 1, -1, 32'h0, 0, 1, 1, 1, 0);       // 11
    add_vec(32'h102080DB, 0, 0, 0, -1, 32'h0, 0, 0, 0, 0, 0);                                 // 12
    add_vec({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 1, 0, 0, -1, 32'h0, 0, 0, 0, 0, 0);       // 13
    add_vec({20'h12345, 5'd4, 7'h7b}, 1, 0, 1, AUICGP, 32'h1234_5000, 0, 0, 0, 1, 0);         // 14
    add_vec({12'hFFE, 5'd1, 3'd0, 5'd0, 7'h67}, 1, 0, 1, CJALR, 32'hFFFF_FFFE, 0, 0, 0, 1, 0); // 15
    add_vec({7'h0b, 5'd3, 5'd1, 3'd0, 5'd2, 7'h5b}, 1, 0, 1, CSEAL, 32'h0, 0, 1, 1, 1, 0);    // 16
    add_vec({12'h000, 5'd1, 3'd5, 5'd2, 7'h5b}, 1, 0, 1, -1, 32'h0, 0, 1, 0, 1, 0);           // 17
    add_vec({7'h21, 5'd3, 5'd1, 3'd0, 5'd2, 7'h5b}, 1, 0, 1, CIS_EQUAL, 32'h0, 0, 1, 1, 1, 0); // 18

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_instr_i = '0; in_pc_i = '0;
    cheri_en_i = 1'b1; cheri_tsafe_en_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_occupancy", occupancy_o, 0);
    chk("rst_in_ready",  in_ready_o, 1);
    chk("rst_operator",  out_operator_o, 0);
    chk("rst_imm",       out_imm_o, 0);
    chk("rst_perf_dec",  perf_decoded_o, 0);
    @(posedge clk_i); #1;

    // Single-cycle op: valid one cycle after enqueue
    push_one(0);
    @(negedge clk_i);
    chk("lat1_valid", out_valid_o, 1);
    @(posedge clk_i); #1;

    // Two-cycle op: one dead cycle, then valid
    push_one(1);
    @(negedge clk_i);
    chk("hold1_valid_low", out_valid_o, 0);
    @(negedge clk_i);
    chk("hold1_then_valid", out_valid_o, 1);
    @(posedge clk_i); #1;

    // Backpressure and pop-through on a full queue
    out_ready_i = 1'b0;
    push_one(2);
    push_one(3);
    start_push(16);
    @(negedge clk_i);
    chk("full_in_ready", in_ready_o, 0);
    chk("full_occupancy", occupancy_o, 2);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    wait_accept(cyc);
    chk("pop_through_cycles", cyc, 1);
    drain();

    // Full vector table with intermittent consumer stalls
    for (int i = 0; i < vecs.size(); i++) begin
      out_ready_i = (i % 3 != 2);
      push_one(i);
    end
    drain();

    // Flush with an instruction offered in the same cycle
    out_ready_i = 1'b0;
    push_one(6);
    push_one(7);
    start_push(13);
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_in_ready", in_ready_o, 1);
    @(posedge clk_i); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    chk("flush_occupancy", occupancy_o, 0);
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_perf_dec", perf_decoded_o, perf_exp(exp_dec));
    chk("flush_perf_ill", perf_illegal_o, perf_exp(exp_ill));
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    push_one(14);
    drain();

    // Reset while the head sits in its dead cycle
    push_one(1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    sb.delete();
    exp_dec = 0; exp_ill = 0;
    @(negedge clk_i);
    chk("rst2_out_valid", out_valid_o, 0);
    chk("rst2_occupancy", occupancy_o, 0);
    chk("rst2_operator",  out_operator_o, 0);
    chk("rst2_imm",       out_imm_o, 0);
    chk("rst2_perf_dec",  perf_decoded_o, 0);
    chk("rst2_perf_ill",  perf_illegal_o, 0);
    @(posedge clk_i); #1;

    // One illegal CHERI instruction counts in both counters
    push_one(11);
    drain();
    @(negedge clk_i);
    chk("perf_dec_one", perf_decoded_o, perf_exp(32'd1));
    chk("perf_ill_one", perf_illegal_o, perf_exp(32'd1));
    chk("perf_dec_model", perf_decoded_o, perf_exp(exp_dec));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
